alu_share_arbiter: RTL
======================

// Module: alu_share_arbiter
// PURPOSE
//   Shares one combinational ALU (4-bit ALUctl, 32-bit A/B, ALUOut, Zero) between two requesters,
//   e.g. the integer issue stage (port 0) and the branch-compare unit (port 1).
//   Round-robin arbitration, registered operands and result, valid/ready handshake on each side.
//   Sits between the requesters and the single ALU instance in the core.
// PARAMETERS
//   DATA_W  32  operand/result width; must match the ALU
//   CTL_W   4   ALU op-select width; must match the ALU
//   CNT_W   16  width of each per-port completed-op counter
// PORTS
//   clk         in   1       clock; all state updates on rising edge
//   rst         in   1       reset: synchronous, active-high
//   req0_valid  in   1       port 0 request present
//   req0_ready  out  1       port 0 request accepted when valid&ready
//   req0_ctl    in   CTL_W   port 0 ALU op
//   req0_a      in   DATA_W  port 0 operand A
//   req0_b      in   DATA_W  port 0 operand B
//   rsp0_valid  out  1       port 0 result present
//   rsp0_ready  in   1       port 0 consumes result when valid&ready
//   rsp0_data   out  DATA_W  port 0 result
//   rsp0_zero   out  1       port 0 Zero flag
//   req1_*/rsp1_*            same as port 0, for port 1
//   alu_ctl     out  CTL_W   to ALU op select
//   alu_a       out  DATA_W  to ALU A
//   alu_b       out  DATA_W  to ALU B
//   alu_out     in   DATA_W  from ALU result
//   alu_zero    in   1       from ALU Zero (alu_out==0)
//   cnt0        out  CNT_W   completed responses, port 0
//   cnt1        out  CNT_W   completed responses, port 1
// BEHAVIOUR
//   FSM: IDLE -> EXEC -> RESP -> IDLE; one op in flight.
//   IDLE:
//     - reqN_ready=1 for the granted port only, other port ready=0.
//     - Grant: single valid wins. Both valid -> port != last_grant. None valid -> stay IDLE.
//     - On handshake: latch ctl/a/b into op regs, latch grant, set last_grant, go EXEC.
//   EXEC: ALU driven from op regs (one full cycle); latch alu_out/alu_zero into result regs; go RESP.
//   RESP:
//     - rspG_valid=1 for granted port G; other port rsp_valid=0.
//     - Hold until rspG_ready; data/zero stable while stalled.
//     - On fire: cntG+=1 (wraps at 2^CNT_W), go IDLE.
//   alu_ctl/alu_a/alu_b always equal op regs (stable outside EXEC; ALU is pure combinational).
//   Latency: accept in cycle N, rsp_valid asserted in cycle N+2. Peak throughput 1 op / 3 cycles.
//   All req_ready=0 in EXEC and RESP; a new request never overlaps a pending response.
//   Ops are not decoded: all 16 ctl codes are legal and passed through.
//     - Compare ops (7,8,11-14) return 0/1 in data; zero mirrors alu_zero.
//   Reset (any state, incl. mid-EXEC/RESP):
//     - Next state IDLE; in-flight op dropped, no response issued.
//     - rsp*_valid=0, last_grant=1 (port 0 wins first tie).
//     - op regs, result regs, cnt0, cnt1 = 0; alu_ctl/a/b = 0.
//     - req*_ready reflect IDLE grant logic from the first cycle after rst deasserts.
//   Input changes on an unaccepted request (valid without ready) are allowed and ignored.
// TESTING
//   1. req0 ctl=2 a=3 b=-7 -> accepted, rsp0_valid 2 cycles later, data=32'hFFFFFFFC zero=0, cnt0=1.
//   2. After reset, req0 and req1 both valid (ctl=0 a=3 b=13; ctl=1 a=5 b=12) ->
//      port0 served first (data=1), then port1 (data=13); grants alternate over 4 back-to-back pairs.
//   3. req1 ctl=12 a=-2 b=-2 with rsp1_ready=0 for 5 cycles -> rsp1_valid held, data=0 zero=1 stable,
//      req0/req1_ready=0 throughout, fires on cycle rsp1_ready rises.
//   4. rst pulsed 1 cycle while in RESP for port0 -> rsp0_valid=0 next cycle, cnt0=0,
//      next tie grants port 0.
//   5. Sweep ctl 0..15 on port 0 (e.g. ctl=15 a=-64 b=5 -> 32'hFFFFFFFE; ctl=13 a=-11 b=1 -> 0)
//      -> data/zero match ALU reference model; cnt0 counts 16.
//   6. Force cnt1=16'hFFFF via 65535 ops (or reduced CNT_W=4) -> next completion wraps cnt1 to 0.

Source files
------------

// File: rtl/alu_share_arbiter_if.sv
// Handshake and ALU bundle between two requesters, the arbiter and the shared ALU.
// Latency: none; this file only groups wires.
// Backpressure: per-port valid/ready on request and response, ready driven by the arbiter.
interface alu_share_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int CTL_W  = 4,
  parameter int CNT_W  = 16
);
  // Port 0 request and response
  logic              req0_valid;
  logic              req0_ready;
  logic [CTL_W-1:0]  req0_ctl;
  logic [DATA_W-1:0] req0_a;
  logic [DATA_W-1:0] req0_b;
  logic              rsp0_valid;
  logic              rsp0_ready;
  logic [DATA_W-1:0] rsp0_data;
  logic              rsp0_zero;

  // Port 1 request and response
  logic              req1_valid;
  logic              req1_ready;
  logic [CTL_W-1:0]  req1_ctl;
  logic [DATA_W-1:0] req1_a;
  logic [DATA_W-1:0] req1_b;
  logic              rsp1_valid;
  logic              rsp1_ready;
  logic [DATA_W-1:0] rsp1_data;
  logic              rsp1_zero;

  // Shared ALU
  logic [CTL_W-1:0]  alu_ctl;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [DATA_W-1:0] alu_out;
  logic              alu_zero;

  // Completed-response counters
  logic [CNT_W-1:0]  cnt0;
  logic [CNT_W-1:0]  cnt1;

  // Arbiter side
  modport slave (
    input  req0_valid, req0_ctl, req0_a, req0_b, rsp0_ready,
    input  req1_valid, req1_ctl, req1_a, req1_b, rsp1_ready,
    input  alu_out, alu_zero,
    output req0_ready, rsp0_valid, rsp0_data, rsp0_zero,
    output req1_ready, rsp1_valid, rsp1_data, rsp1_zero,
    output alu_ctl, alu_a, alu_b,
    output cnt0, cnt1
  );

  // Requester / ALU / observer side
  modport master (
    output req0_valid, req0_ctl, req0_a, req0_b, rsp0_ready,
    output req1_valid, req1_ctl, req1_a, req1_b, rsp1_ready,
    output alu_out, alu_zero,
    input  req0_ready, rsp0_valid, rsp0_data, rsp0_zero,
    input  req1_ready, rsp1_valid, rsp1_data, rsp1_zero,
    input  alu_ctl, alu_a, alu_b,
    input  cnt0, cnt1
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one combinational ALU between two requesters, one op in flight.
// Latency: request accepted in cycle N, response valid in cycle N+2; peak 1 op per 3 cycles.
// Backpressure: request ready only in IDLE for the granted port; response held until its ready.
module alu_share_arbiter #(
  parameter int DATA_W = 32,
  parameter int CTL_W  = 4,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  alu_share_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t            state_q;
  state_t            state_d;
  logic              last_grant_q;
  logic              grant_q;
  logic [CTL_W-1:0]  op_ctl_q;
  logic [DATA_W-1:0] op_a_q;
  logic [DATA_W-1:0] op_b_q;
  logic [DATA_W-1:0] res_data_q;
  logic              res_zero_q;
  logic [CNT_W-1:0]  cnt0_q;
  logic [CNT_W-1:0]  cnt1_q;

  logic              any_req;
  logic              pick;
  logic              accept;
  logic              rsp_fire;
  logic              req0_ready;
  logic              req1_ready;
  logic              rsp0_valid;
  logic              rsp1_valid;

  // Round-robin pick: a lone requester wins, a tie goes to the port not served last
  always_comb begin
    any_req = bus.req0_valid | bus.req1_valid;
    pick    = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      pick = ~last_grant_q;
    end else begin
      pick = bus.req1_valid;
    end
  end

  // Next state and handshake outputs; ready only offered in IDLE so ops never overlap
  always_comb begin
    state_d    = state_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    accept     = 1'b0;
    rsp_fire   = 1'b0;
    case (state_q)
      IDLE: begin
        req0_ready = any_req & ~pick;
        req1_ready = any_req & pick;
        if (any_req) begin
          accept  = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        state_d = RESP;
      end
      RESP: begin
        rsp0_valid = ~grant_q;
        rsp1_valid = grant_q;
        if ((grant_q && bus.rsp1_ready) || (!grant_q && bus.rsp0_ready)) begin
          rsp_fire = 1'b1;
          state_d  = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register; reset abandons any op in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Capture the winning request's operands and remember who was served
  always_ff @(posedge clk) begin
    if (rst) begin
      op_ctl_q     <= '0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
    end else if (accept) begin
      op_ctl_q     <= pick ? bus.req1_ctl : bus.req0_ctl;
      op_a_q       <= pick ? bus.req1_a   : bus.req0_a;
      op_b_q       <= pick ? bus.req1_b   : bus.req0_b;
      grant_q      <= pick;
      last_grant_q <= pick;
    end
  end

  // ALU has had a full cycle to settle on the op regs; register its result
  always_ff @(posedge clk) begin
    if (rst) begin
      res_data_q <= '0;
      res_zero_q <= 1'b0;
    end else if (state_q == EXEC) begin
      res_data_q <= bus.alu_out;
      res_zero_q <= bus.alu_zero;
    end
  end

  // Count completed responses per port, wrapping naturally
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else if (rsp_fire) begin
      if (grant_q) begin
        cnt1_q <= cnt1_q + CNT_ONE;
      end else begin
        cnt0_q <= cnt0_q + CNT_ONE;
      end
    end
  end

  assign bus.req0_ready = req0_ready;
  assign bus.req1_ready = req1_ready;
  assign bus.rsp0_valid = rsp0_valid;
  assign bus.rsp1_valid = rsp1_valid;
  assign bus.rsp0_data  = res_data_q;
  assign bus.rsp1_data  = res_data_q;
  assign bus.rsp0_zero  = res_zero_q;
  assign bus.rsp1_zero  = res_zero_q;
  assign bus.alu_ctl    = op_ctl_q;
  assign bus.alu_a      = op_a_q;
  assign bus.alu_b      = op_b_q;
  assign bus.cnt0       = cnt0_q;
  assign bus.cnt1       = cnt1_q;

endmodule
